filter_readout_sched: RTL and testbench

Peak-hold and readout scheduler for the filter bank. It tracks the signed maximum of every filter output between triggers. On each trigger it snapshots the per-channel peaks. It then serialises the enabled channels, one per handshake, onto a single valid/ready stream. It sits between the filter variants (fed by the exponential signal generator) and the readout/host interface, so the bank shares one output port.

---
 rtl/package_settings.sv | 21 ++
 rtl/filter_peak_hold.sv | 51 +++++
 rtl/filter_readout_sched.sv | 185 ++++++++++++++++++
 tb/tb_filter_readout_sched.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/package_settings.sv
// ---------------------------------------------------------------------------
// package_settings
//   Shared constants and types for the filter bank and its readout path.
//   - SIZE_FILTER_DATA : filter sample width (two's complement)
//   - NUM_FILTERS      : number of filter channels in the bank
//   - filt_sample_t    : signed filter sample
//   - rd_state_t       : readout scheduler FSM states
// ---------------------------------------------------------------------------
package package_settings;

    localparam int SIZE_FILTER_DATA = 16;
    localparam int NUM_FILTERS      = 21;

    typedef logic signed [SIZE_FILTER_DATA-1:0] filt_sample_t;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SCAN
    } rd_state_t;

endpackage

// File: rtl/filter_peak_hold.sv
// ---------------------------------------------------------------------------
// filter_peak_hold
//   Per-channel signed running maximum with snapshot-and-clear.
//   Ports:
//     clk, reset  : clock, async active-high reset
//     din         : channel sample this cycle (two's complement)
//     capture     : close the frame this cycle: snapshot the max (including
//                   din) and restart tracking from MIN
//     cur_max     : max(peak, din), combinational, used to preload the first
//                   readout word on the capture cycle
//     snap        : registered snapshot of the last closed frame
// ---------------------------------------------------------------------------
module filter_peak_hold
    import package_settings::*;
#(
    parameter int DATA_W = SIZE_FILTER_DATA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              capture,
    output logic [DATA_W-1:0] cur_max,
    output logic [DATA_W-1:0] snap
);

    localparam logic [DATA_W-1:0] MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] peak_q, peak_d;
    logic [DATA_W-1:0] snap_q, snap_d;

    always_comb begin
        cur_max = ($signed(din) > $signed(peak_q)) ? din : peak_q;
        // The capture-cycle sample belongs to the closing frame; the new
        // frame starts empty.
        peak_d  = capture ? MIN : cur_max;
        snap_d  = capture ? cur_max : snap_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_q <= MIN;
            snap_q <= '0;
        end else begin
            peak_q <= peak_d;
            snap_q <= snap_d;
        end
    end

    assign snap = snap_q;

endmodule

// File: rtl/filter_readout_sched.sv
// ---------------------------------------------------------------------------
// filter_readout_sched
//   Peak-hold and readout scheduler for the filter bank. Tracks the signed
//   maximum of every channel between triggers, snapshots on trigger, then
//   streams the enabled channels' peaks one per handshake.
//   Ports:
//     clk, reset     : clock, async active-high reset
//     ch_data        : per-channel filter samples
//     ch_mask        : channel enables, sampled on an accepted trigger
//     trigger        : frame trigger
//     clear_overrun  : clears the sticky overrun flag
//     out_valid/out_ready/out_data/out_ch/out_last : readout stream
//     busy           : readout in progress
//     frame_done     : one-cycle pulse after the final handshake
//     overrun        : sticky, trigger seen while busy
// ---------------------------------------------------------------------------
module filter_readout_sched
    import package_settings::*;
#(
    parameter int NUM_CH = NUM_FILTERS,
    parameter int DATA_W = SIZE_FILTER_DATA,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_data,
    input  logic [NUM_CH-1:0]              ch_mask,
    input  logic                           trigger,
    input  logic                           clear_overrun,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic [CH_W-1:0]                out_ch,
    output logic                           out_last,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           overrun
);

    localparam logic [NUM_CH-1:0] ONE = {{(NUM_CH-1){1'b0}}, 1'b1};

    // Lowest set bit index; disabled channels are skipped in one step.
    function automatic logic [CH_W-1:0] lowest_bit(input logic [NUM_CH-1:0] m);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH-1; i >= 0; i--) begin
            if (m[i]) idx = CH_W'(i);
        end
        return idx;
    endfunction

    function automatic logic single_bit(input logic [NUM_CH-1:0] m);
        return (m != '0) && ((m & (m - ONE)) == '0);
    endfunction

    // ---------------------------------------------------------------
    // Per-channel peak hold
    // ---------------------------------------------------------------
    logic                          capture;
    logic [NUM_CH-1:0][DATA_W-1:0] cur_max_w;
    logic [NUM_CH-1:0][DATA_W-1:0] snap_w;

    rd_state_t         state_q, state_d;
    logic [NUM_CH-1:0] rem_q, rem_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              overrun_q, overrun_d;

    // Triggers during SCAN never close a frame; tracking just continues.
    assign capture = trigger && (state_q == ST_IDLE);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        filter_peak_hold #(.DATA_W(DATA_W)) u_peak (
            .clk     (clk),
            .reset   (reset),
            .din     (ch_data[g]),
            .capture (capture),
            .cur_max (cur_max_w[g]),
            .snap    (snap_w[g])
        );
    end

    // ---------------------------------------------------------------
    // Scheduler
    // ---------------------------------------------------------------
    logic [NUM_CH-1:0] rem_nx;
    logic [CH_W-1:0]   nxt_ch;

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        out_last_d   = out_last_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        rem_nx       = '0;
        nxt_ch       = '0;

        if (clear_overrun) overrun_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    rem_d = ch_mask;
                    if (ch_mask != '0) begin
                        // Snapshot registers load on this same edge, so the
                        // first word comes from the combinational max.
                        nxt_ch      = lowest_bit(ch_mask);
                        state_d     = ST_SCAN;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        out_ch_d    = nxt_ch;
                        out_data_d  = cur_max_w[nxt_ch];
                        out_last_d  = single_bit(ch_mask);
                    end else begin
                        frame_done_d = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                // Set wins over clear_overrun.
                if (trigger) overrun_d = 1'b1;
                // out_valid is always high in SCAN, so ready alone is a
                // handshake.
                if (out_ready) begin
                    rem_nx = rem_q & ~(ONE << out_ch_q);
                    rem_d  = rem_nx;
                    if (rem_nx == '0) begin
                        state_d      = ST_IDLE;
                        out_valid_d  = 1'b0;
                        busy_d       = 1'b0;
                        out_last_d   = 1'b0;
                        frame_done_d = 1'b1;
                    end else begin
                        nxt_ch     = lowest_bit(rem_nx);
                        out_ch_d   = nxt_ch;
                        out_data_d = snap_w[nxt_ch];
                        out_last_d = single_bit(rem_nx);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rem_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_ch     = out_ch_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_filter_readout_sched.sv
// ---------------------------------------------------------------------------
// tb_filter_readout_sched
//   Directed and randomized stimulus against a queue-based reference model:
//   an accepted trigger turns the closed frame into a list of words; the
//   stream shows the list head, and each handshake pops it.
// ---------------------------------------------------------------------------
module tb_filter_readout_sched;

    localparam int N = 21;
    localparam int W = 16;
    localparam int CW = 5;
    localparam logic signed [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0][W-1:0]  ch_data;
    logic [N-1:0]         ch_mask;
    logic                 trigger;
    logic                 clear_overrun;
    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         out_data;
    logic [CW-1:0]        out_ch;
    logic                 out_last;
    logic                 busy;
    logic                 frame_done;
    logic                 overrun;

    filter_readout_sched #(.NUM_CH(N), .DATA_W(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .ch_data       (ch_data),
        .ch_mask       (ch_mask),
        .trigger       (trigger),
        .clear_overrun (clear_overrun),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_ch        (out_ch),
        .out_last      (out_last),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [CW-1:0] ch;
        logic [W-1:0]  data;
        logic          last;
    } word_t;

    logic signed [W-1:0] m_peak [N];
    word_t               m_q [$];
    logic                m_fd;
    logic                m_ov;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_peak[i] = MIN;
        m_q.delete();
        m_fd = 1'b0;
        m_ov = 1'b0;
    endtask

    // Called just after a rising edge, with the inputs that edge sampled.
    task automatic model_edge();
        bit                  busy0;
        bit                  acc;
        int                  last_i;
        logic signed [W-1:0] d, v;
        logic signed [W-1:0] snapv [N];
        word_t               w;
        busy0 = (m_q.size() != 0);
        acc   = trigger && !busy0;
        m_fd  = 1'b0;
        if (busy0 && out_ready) begin
            w = m_q.pop_front();
            if (m_q.size() == 0) m_fd = 1'b1;
        end
        if (trigger && busy0) m_ov = 1'b1;
        else if (clear_overrun) m_ov = 1'b0;
        for (int i = 0; i < N; i++) begin
            d = ch_data[i];
            v = (d > m_peak[i]) ? d : m_peak[i];
            snapv[i] = v;
            m_peak[i] = acc ? MIN : v;
        end
        if (acc) begin
            if (ch_mask == '0) begin
                m_fd = 1'b1;
            end else begin
                last_i = 0;
                for (int i = 0; i < N; i++) if (ch_mask[i]) last_i = i;
                for (int i = 0; i < N; i++) begin
                    if (ch_mask[i]) begin
                        w.ch   = CW'(i);
                        w.data = snapv[i];
                        w.last = (i == last_i);
                        m_q.push_back(w);
                    end
                end
            end
        end
    endtask

    task automatic check_outs();
        chk("out_valid",  32'(out_valid),  32'(m_q.size() != 0));
        chk("busy",       32'(busy),       32'(m_q.size() != 0));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("overrun",    32'(overrun),    32'(m_ov));
        if (m_q.size() != 0) begin
            chk("out_ch",   32'(out_ch),   32'(m_q[0].ch));
            chk("out_data", 32'(out_data), 32'(m_q[0].data));
            chk("out_last", 32'(out_last), 32'(m_q[0].last));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outs();
    endtask

    task automatic set_all(input logic [W-1:0] v);
        for (int i = 0; i < N; i++) ch_data[i] = v;
    endtask

    initial begin
        reset = 1'b1;
        set_all('0);
        ch_mask = '0;
        trigger = 1'b0;
        clear_overrun = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_out_data",   32'(out_data),   32'd0);
        chk("rst_out_ch",     32'(out_ch),     32'd0);
        chk("rst_out_last",   32'(out_last),   32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overrun",    32'(overrun),    32'd0);
        model_reset();
        reset = 1'b0;

        // Basic frame: ch0=100, ch1=-5, ch2=32767, continuous ready.
        set_all(16'h8000);
        ch_data[0] = 16'd100;
        ch_data[1] = 16'hFFFB;
        ch_data[2] = 16'h7FFF;
        out_ready = 1'b1;
        repeat (2) cyc();
        trigger = 1'b1; ch_mask = 21'h7;
        cyc();
        trigger = 1'b0;
        repeat (4) cyc();

        // Sparse mask: channels 3 and 20 only.
        set_all(16'h0123);
        ch_data[20] = 16'hFF00;
        cyc();
        trigger = 1'b1; ch_mask = 21'h100008;
        cyc();
        trigger = 1'b0;
        repeat (3) cyc();

        // Backpressure: ready low for 5 cycles after the first valid.
        for (int i = 0; i < N; i++) ch_data[i] = W'(i * 37 - 300);
        cyc();
        trigger = 1'b1; ch_mask = 21'h1F0;
        cyc();
        trigger = 1'b0; out_ready = 1'b0;
        repeat (5) cyc();
        out_ready = 1'b1;
        repeat (7) cyc();

        // Overrun: trigger while busy, larger samples before and after.
        set_all(16'd10);
        trigger = 1'b1; ch_mask = 21'h3; out_ready = 1'b0;
        cyc();
        trigger = 1'b0; set_all(16'd500);
        cyc();
        trigger = 1'b1; set_all(16'd20);
        cyc();
        trigger = 1'b0; set_all(16'd30);
        cyc();
        // clear and overrun trigger together: set wins
        trigger = 1'b1; clear_overrun = 1'b1;
        cyc();
        trigger = 1'b0; clear_overrun = 1'b0; out_ready = 1'b1;
        repeat (3) cyc();
        trigger = 1'b1; ch_mask = 21'h3;
        cyc();
        trigger = 1'b0; clear_overrun = 1'b1;
        repeat (3) cyc();
        clear_overrun = 1'b0;

        // Zero mask: no words, frame_done one cycle after trigger.
        trigger = 1'b1; ch_mask = '0;
        cyc();
        trigger = 1'b0;
        repeat (2) cyc();

        // Trigger-cycle sample 200 above prior peak 50; next frame from MIN.
        set_all(16'hFFF0);
        ch_data[0] = 16'd50;
        repeat (2) cyc();
        ch_data[0] = 16'd200; trigger = 1'b1; ch_mask = 21'h1;
        cyc();
        ch_data[0] = 16'd10; trigger = 1'b0;
        repeat (2) cyc();
        trigger = 1'b1;
        cyc();
        trigger = 1'b0;
        repeat (2) cyc();

        // Async reset mid-SCAN, between clock edges.
        for (int i = 0; i < N; i++) ch_data[i] = W'($urandom);
        trigger = 1'b1; ch_mask = 21'hFF; out_ready = 1'b0;
        cyc();
        trigger = 1'b0;
        cyc();
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_busy",  32'(busy),      32'd0);
        model_reset();
        @(negedge clk);
        chk("async_rst_fd", 32'(frame_done), 32'd0);
        reset = 1'b0;
        // All-negative data after reset exposes a non-MIN peak.
        set_all(16'h8005);
        ch_data[4] = 16'hC000;
        out_ready = 1'b1;
        cyc();
        trigger = 1'b1; ch_mask = 21'h11;
        cyc();
        trigger = 1'b0;
        repeat (3) cyc();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++) ch_data[i] = W'($urandom);
            trigger = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       ch_mask = '0;
                1:       ch_mask = N'(1) << $urandom_range(0, N-1);
                default: ch_mask = N'($urandom);
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            clear_overrun = ($urandom_range(0, 19) == 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
